// File: rtl/strided_addr_gen_nch.sv
// Multi-channel 1D/2D strided address generator with per-channel ready/valid
// request ports, abort, wrap-around addressing, done and config-error pulses.
module strided_addr_gen_nch #(
    parameter int NCH = 2,
    parameter int AW  = 5,
    parameter int CW  = 8,
    parameter int OCW = 4,
    parameter int SW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       cfg_valid,
    input  logic [NCH-1:0]       cfg_we,
    input  logic [NCH*AW-1:0]    cfg_base,
    input  logic [NCH*CW-1:0]    cfg_count,
    input  logic [NCH*SW-1:0]    cfg_stride,
    input  logic [NCH*OCW-1:0]   cfg_ocount,
    input  logic [NCH*SW-1:0]    cfg_ostride,
    input  logic [NCH-1:0]       abort,
    input  logic [NCH-1:0]       req_ready,
    output logic [NCH-1:0]       req_valid,
    output logic [NCH*AW-1:0]    req_addr,
    output logic [NCH-1:0]       req_we,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic [NCH-1:0]       cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_t          state_q, state_d;
        logic [AW-1:0]   addr_q, addr_d;
        logic [AW-1:0]   row_base_q, row_base_d;
        logic [CW-1:0]   i_q, i_d;
        logic [CW-1:0]   count_q, count_d;
        logic [OCW-1:0]  j_q, j_d;
        logic [OCW-1:0]  ocount_q, ocount_d;
        logic [SW-1:0]   stride_q, stride_d;
        logic [SW-1:0]   ostride_q, ostride_d;
        logic            we_q, we_d;
        logic            cfg_err_q, cfg_err_d;
        logic [AW-1:0]   next_row;
        logic            fire;
        logic            run;

        assign run      = (state_q == S_RUN);
        assign fire     = run && req_ready[c];
        assign next_row = row_base_q + AW'(ostride_q);

        always_comb begin
            state_d    = state_q;
            addr_d     = addr_q;
            row_base_d = row_base_q;
            i_d        = i_q;
            j_d        = j_q;
            count_d    = count_q;
            ocount_d   = ocount_q;
            stride_d   = stride_q;
            ostride_d  = ostride_q;
            we_d       = we_q;
            cfg_err_d  = 1'b0;

            case (state_q)
                S_IDLE: begin
                    // abort is meaningless here, so a simultaneous cfg simply wins
                    if (cfg_valid[c]) begin
                        count_d    = cfg_count[c*CW +: CW];
                        ocount_d   = cfg_ocount[c*OCW +: OCW];
                        stride_d   = cfg_stride[c*SW +: SW];
                        ostride_d  = cfg_ostride[c*SW +: SW];
                        we_d       = cfg_we[c];
                        addr_d     = cfg_base[c*AW +: AW];
                        row_base_d = cfg_base[c*AW +: AW];
                        i_d        = '0;
                        j_d        = '0;
                        if (cfg_count[c*CW +: CW] == '0 || cfg_ocount[c*OCW +: OCW] == '0)
                            state_d = S_DONE;
                        else
                            state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    cfg_err_d = cfg_valid[c];
                    if (abort[c]) begin
                        state_d = S_IDLE;
                    end else if (fire) begin
                        if (i_q != count_q - CW'(1)) begin
                            i_d    = i_q + CW'(1);
                            addr_d = addr_q + AW'(stride_q);
                        end else if (j_q != ocount_q - OCW'(1)) begin
                            i_d        = '0;
                            j_d        = j_q + OCW'(1);
                            row_base_d = next_row;
                            addr_d     = next_row;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    cfg_err_d = cfg_valid[c];
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q    <= S_IDLE;
                addr_q     <= '0;
                row_base_q <= '0;
                i_q        <= '0;
                j_q        <= '0;
                count_q    <= '0;
                ocount_q   <= '0;
                stride_q   <= '0;
                ostride_q  <= '0;
                we_q       <= 1'b0;
                cfg_err_q  <= 1'b0;
            end else begin
                state_q    <= state_d;
                addr_q     <= addr_d;
                row_base_q <= row_base_d;
                i_q        <= i_d;
                j_q        <= j_d;
                count_q    <= count_d;
                ocount_q   <= ocount_d;
                stride_q   <= stride_d;
                ostride_q  <= ostride_d;
                we_q       <= we_d;
                cfg_err_q  <= cfg_err_d;
            end
        end

        // Outputs are pure functions of registered state: no path from req_ready.
        assign req_valid[c]           = run;
        assign busy[c]                = run;
        assign done[c]                = (state_q == S_DONE);
        assign cfg_err[c]             = cfg_err_q;
        assign req_addr[c*AW +: AW]   = run ? addr_q : '0;
        assign req_we[c]              = run && we_q;
    end

endmodule

// File: tb/tb_strided_addr_gen_nch.sv
// Bench for strided_addr_gen_nch: directed scenarios plus random streams,
// checked against per-channel queues of expected addresses.
module tb_strided_addr_gen_nch;
    localparam int NCH = 2;
    localparam int AW  = 5;
    localparam int CW  = 8;
    localparam int OCW = 4;
    localparam int SW  = 4;

    logic               clk;
    logic               rst;
    logic [NCH-1:0]     cfg_valid, cfg_we, abort, req_ready;
    logic [NCH*AW-1:0]  cfg_base;
    logic [NCH*CW-1:0]  cfg_count;
    logic [NCH*SW-1:0]  cfg_stride, cfg_ostride;
    logic [NCH*OCW-1:0] cfg_ocount;
    logic [NCH-1:0]     req_valid, req_we, busy, done, cfg_err;
    logic [NCH*AW-1:0]  req_addr;

    strided_addr_gen_nch #(.NCH(NCH), .AW(AW), .CW(CW), .OCW(OCW), .SW(SW)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_we(cfg_we), .cfg_base(cfg_base),
        .cfg_count(cfg_count), .cfg_stride(cfg_stride), .cfg_ocount(cfg_ocount),
        .cfg_ostride(cfg_ostride), .abort(abort), .req_ready(req_ready),
        .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int          expq [NCH][$];
    logic        exp_we [NCH];
    int          hs_cnt [NCH];
    int          done_cnt [NCH];
    int          err_cnt [NCH];
    int          busy_cnt [NCH];
    logic [NCH-1:0] s_valid, s_done, s_busy, s_err;
    int          s_addr [NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clr_stats();
        for (int c = 0; c < NCH; c++) begin
            hs_cnt[c] = 0; done_cnt[c] = 0; err_cnt[c] = 0; busy_cnt[c] = 0;
        end
    endtask

    // One clock: sample and score at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            s_valid[c] = req_valid[c];
            s_done[c]  = done[c];
            s_busy[c]  = busy[c];
            s_err[c]   = cfg_err[c];
            s_addr[c]  = int'(req_addr[c*AW +: AW]);
            if (busy[c]) busy_cnt[c]++;
            if (req_valid[c]) begin
                chk("valid_has_pending", (expq[c].size() != 0), 1);
                if (expq[c].size() != 0) begin
                    chk("addr", req_addr[c*AW +: AW], expq[c][0]);
                    chk("we", req_we[c], exp_we[c]);
                    if (req_ready[c]) begin
                        void'(expq[c].pop_front());
                        hs_cnt[c]++;
                    end
                end
            end
            if (done[c]) begin
                done_cnt[c]++;
                chk("done_after_last", expq[c].size(), 0);
            end
            if (cfg_err[c]) err_cnt[c]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input int c, input int base, input int cnt, input int str,
                             input int ocnt, input int ostr, input bit we);
        cfg_valid[c]            = 1'b1;
        cfg_we[c]               = we;
        cfg_base[c*AW +: AW]    = base[AW-1:0];
        cfg_count[c*CW +: CW]   = cnt[CW-1:0];
        cfg_stride[c*SW +: SW]  = str[SW-1:0];
        cfg_ocount[c*OCW +: OCW] = ocnt[OCW-1:0];
        cfg_ostride[c*SW +: SW] = ostr[SW-1:0];
    endtask

    // Reference: element (j,i) of a stream lives at base + j*ostride + i*stride, mod 2^AW.
    task automatic start(input int c, input int base, input int cnt, input int str,
                         input int ocnt, input int ostr, input bit we);
        drive_cfg(c, base, cnt, str, ocnt, ostr, we);
        exp_we[c] = we;
        for (int j = 0; j < ocnt; j++)
            for (int i = 0; i < cnt; i++)
                expq[c].push_back((base + j*ostr + i*str) % (1 << AW));
    endtask

    task automatic run_until_done(input int c, input int budget);
        int d0 = done_cnt[c];
        for (int k = 0; k < budget && done_cnt[c] == d0; k++) tick();
        chk("done_within_budget", done_cnt[c] - d0, 1);
    endtask

    initial begin
        rst = 1'b0;
        cfg_valid = '0; cfg_we = '0; cfg_base = '0; cfg_count = '0;
        cfg_stride = '0; cfg_ocount = '0; cfg_ostride = '0;
        abort = '0; req_ready = '0;
        for (int c = 0; c < NCH; c++) exp_we[c] = 1'b0;
        clr_stats();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_addr", req_addr, 0);
        chk("rst_we", req_we, 0);
        rst = 1'b1;
        tick();

        // 1D stream on ch0
        req_ready = '1;
        start(0, 0, 3, 1, 1, 0, 1'b1);
        tick();
        chk("t1_no_valid_in_cfg_cycle", s_valid[0], 0);
        cfg_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t1_valid", s_valid[0], 1);
        end
        tick();
        chk("t1_done", s_done[0], 1);
        chk("t1_valid_drop", s_valid[0], 0);
        chk("t1_busy_drop", s_busy[0], 0);
        tick();
        chk("t1_done_one_cycle", s_done[0], 0);
        chk("t1_hs", hs_cnt[0], 3);
        chk("t1_busy_cycles", busy_cnt[0], 3);

        // 2D stream with wrap on ch1
        clr_stats();
        start(1, 28, 2, 2, 3, 4, 1'b0);
        tick();
        cfg_valid = '0;
        run_until_done(1, 20);
        chk("t2_hs", hs_cnt[1], 6);
        chk("t2_no_err", err_cnt[1], 0);

        // Backpressure on ch0
        clr_stats();
        start(0, 0, 4, 1, 1, 0, 1'b1);
        tick();
        cfg_valid = '0;
        begin
            logic [6:0] pat;
            pat = 7'b1011001;
            for (int k = 6; k >= 0; k--) begin
                req_ready[0] = pat[k];
                tick();
            end
        end
        chk("t3_hs", hs_cnt[0], 4);
        chk("t3_done_not_early", done_cnt[0], 0);
        req_ready[0] = 1'b1;
        tick();
        chk("t3_done", s_done[0], 1);

        // Zero count on ch1
        clr_stats();
        start(1, 7, 0, 1, 1, 0, 1'b1);
        tick();
        chk("t4_zero_valid0", s_valid[1], 0);
        cfg_valid = '0;
        tick();
        chk("t4_zero_done", s_done[1], 1);
        chk("t4_zero_valid1", s_valid[1], 0);

        // cfg during an active stream is rejected
        clr_stats();
        start(0, 3, 5, 2, 1, 0, 1'b0);
        tick();
        cfg_valid = '0;
        tick();
        drive_cfg(0, 20, 9, 7, 2, 3, 1'b1);
        tick();
        cfg_valid = '0;
        tick();
        chk("t4_cfg_err", s_err[0], 1);
        tick();
        chk("t4_cfg_err_pulse", s_err[0], 0);
        run_until_done(0, 20);
        chk("t4_hs", hs_cnt[0], 5);
        chk("t4_err_cnt", err_cnt[0], 1);

        // Abort ch0 while ch1 runs concurrently
        clr_stats();
        start(0, 0, 6, 1, 1, 0, 1'b1);
        start(1, 1, 4, 3, 2, 5, 1'b0);
        tick();
        cfg_valid = '0;
        tick();
        tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        expq[0].delete();
        tick();
        chk("t5_abort_valid", s_valid[0], 0);
        chk("t5_abort_busy", s_busy[0], 0);
        run_until_done(1, 20);
        chk("t5_ch0_hs", hs_cnt[0], 3);
        chk("t5_ch0_no_done", done_cnt[0], 0);
        chk("t5_ch1_hs", hs_cnt[1], 8);

        // Asynchronous reset mid-stream
        clr_stats();
        start(0, 0, 8, 1, 1, 0, 1'b1);
        tick();
        cfg_valid = '0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", req_valid[0], 0);
        chk("t6_rst_busy", busy[0], 0);
        chk("t6_rst_done", done[0], 0);
        chk("t6_rst_addr", req_addr[0 +: AW], 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expq[0].delete();
        clr_stats();
        start(0, 5, 3, 1, 1, 0, 1'b1);
        tick();
        cfg_valid = '0;
        tick();
        chk("t6_restart_valid", s_valid[0], 1);
        chk("t6_restart_addr", s_addr[0], 5);
        run_until_done(0, 20);
        chk("t6_hs", hs_cnt[0], 3);

        // Random streams on both channels with random backpressure
        for (int r = 0; r < 6; r++) begin
            int d0 [NCH];
            int tot [NCH];
            clr_stats();
            for (int c = 0; c < NCH; c++) begin
                int b, n, s, o, os;
                b  = $urandom_range(31, 0);
                n  = $urandom_range(4, 0);
                s  = $urandom_range(15, 0);
                o  = $urandom_range(3, 0);
                os = $urandom_range(15, 0);
                tot[c] = n * o;
                start(c, b, n, s, o, os, 1'($urandom_range(1, 0)));
                d0[c] = done_cnt[c];
            end
            tick();
            cfg_valid = '0;
            for (int k = 0; k < 150 && (done_cnt[0] == d0[0] || done_cnt[1] == d0[1]); k++) begin
                req_ready = NCH'($urandom);
                tick();
            end
            for (int c = 0; c < NCH; c++) begin
                chk("rnd_done", done_cnt[c] - d0[c], 1);
                chk("rnd_hs", hs_cnt[c], tot[c]);
                chk("rnd_q_empty", expq[c].size(), 0);
                expq[c].delete();
            end
            req_ready = '1;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
